// File: rtl/spi_seq_ctrl_pkg.sv
// rtl/spi_seq_ctrl_pkg.sv - register map, bit indices and FSM encoding for spi_seq_ctrl
package nhci_spi_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_INT_SYNC = 4;

  localparam int CTRL_SS_FORCE = 0;
  localparam int CTRL_IRQ_EN   = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/spi_seq_ctrl_if.sv
// rtl/spi_seq_ctrl_if.sv - host register bus and SPI pin bundle for spi_seq_ctrl
interface spi_seq_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       irq;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic       INT;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, MISO, INT,
    input  rd_data, busy, irq, SS, SCLK, MOSI
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, MISO, INT,
    output rd_data, busy, irq, SS, SCLK, MOSI
  );
endinterface

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - 8-bit FIFO, depth 2**AW; push on full drops unless a pop happens in the same cycle
module spi_byte_fifo #(
  parameter int AW = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(1 << AW);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_cnt == DEPTH);
  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/spi_seq_ctrl.sv
// rtl/spi_seq_ctrl.sv - SPI mode-0 master sequencer with TX/RX FIFOs and register window
// Optional SPI_AUTO_SS_EN: hardware asserts SS from the first LOAD until the DONE that returns to IDLE.
import nhci_spi_pkg::*;

module spi_seq_ctrl #(
  parameter int FIFO_AW   = 2,
  parameter int DIV_RESET = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  spi_seq_ctrl_if.slave bus
);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_shreg, r_div, r_div_lat, r_cnt;
  logic [2:0] r_bit;
  logic       r_sclk, r_mosi, r_ss_force, r_irq_en, r_rx_ovf;
  logic       r_int_meta, r_int_sync, r_irq;
  logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_half_done, w_busy;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_auto_ss;
  logic [7:0] w_tx_data, w_rx_data, w_rd_data;

  assign w_tx_push   = bus.wr_en & (bus.wr_addr == REG_DATA);
  assign w_rx_pop    = bus.rd_en & (bus.rd_addr == REG_DATA);
  assign w_tx_pop    = (r_state == LOAD);
  assign w_rx_push   = (r_state == DONE);
  assign w_half_done = (r_cnt == r_div_lat);
  assign w_busy      = (r_state != IDLE) | ~w_tx_empty;

  spi_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .i_clk(CLK), .i_rst_n(RESET), .i_push(w_tx_push), .i_data(bus.wr_data),
    .i_pop(w_tx_pop), .o_data(w_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  spi_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .i_clk(CLK), .i_rst_n(RESET), .i_push(w_rx_push), .i_data(r_shreg),
    .i_pop(w_rx_pop), .o_data(w_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_tx_empty) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = LO;
      LO:      if (w_half_done) w_state_nxt = HI;
      HI:      if (w_half_done) w_state_nxt = (r_bit == 3'd7) ? DONE : LO;
      DONE:    w_state_nxt = w_tx_empty ? IDLE : LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift on the rising SCLK edge so shreg[7] already holds the next MOSI bit at the fall.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_shreg   <= '0;
      r_div_lat <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_shreg   <= w_tx_data;
          r_mosi    <= w_tx_data[7];
          r_div_lat <= r_div;
          r_cnt     <= '0;
          r_bit     <= '0;
        end
        LO: begin
          if (w_half_done) begin
            r_sclk  <= 1'b1;
            r_shreg <= {r_shreg[6:0], bus.MISO};
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HI: begin
          if (w_half_done) begin
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            if (r_bit != 3'd7) begin
              r_mosi <= r_shreg[7];
              r_bit  <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_div      <= 8'(DIV_RESET);
      r_ss_force <= 1'b0;
      r_irq_en   <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_int_meta <= 1'b0;
      r_int_sync <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (bus.wr_en && bus.wr_addr == REG_CTRL) begin
        r_ss_force <= bus.wr_data[CTRL_SS_FORCE];
        r_irq_en   <= bus.wr_data[CTRL_IRQ_EN];
      end
      if (bus.wr_en && bus.wr_addr == REG_DIV) r_div <= bus.wr_data;
      if (w_rx_push && w_rx_full && !w_rx_pop)
        r_rx_ovf <= 1'b1;
      else if (bus.wr_en && bus.wr_addr == REG_STATUS && bus.wr_data[ST_RX_OVF])
        r_rx_ovf <= 1'b0;
      r_int_meta <= bus.INT;
      r_int_sync <= r_int_meta;
      r_irq      <= r_irq_en & (~w_rx_empty | r_int_sync);
    end
  end

`ifdef SPI_AUTO_SS_EN
  logic r_auto_ss;
  always_ff @(posedge CLK) begin
    if (!RESET)                                        r_auto_ss <= 1'b0;
    else if (w_state_nxt == LOAD)                      r_auto_ss <= 1'b1;
    else if (r_state == DONE && w_state_nxt == IDLE)   r_auto_ss <= 1'b0;
  end
  assign w_auto_ss = r_auto_ss;
`else
  assign w_auto_ss = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (bus.rd_addr)
      REG_DATA: w_rd_data = w_rx_empty ? 8'h00 : w_rx_data;
      REG_STATUS: begin
        w_rd_data[ST_BUSY]     = w_busy;
        w_rd_data[ST_TX_FULL]  = w_tx_full;
        w_rd_data[ST_RX_EMPTY] = w_rx_empty;
        w_rd_data[ST_RX_OVF]   = r_rx_ovf;
        w_rd_data[ST_INT_SYNC] = r_int_sync;
      end
      REG_CTRL: begin
        w_rd_data[CTRL_SS_FORCE] = r_ss_force;
        w_rd_data[CTRL_IRQ_EN]   = r_irq_en;
      end
      default:  w_rd_data = r_div;
    endcase
  end

  assign bus.rd_data = w_rd_data;
  assign bus.busy    = w_busy;
  assign bus.irq     = r_irq;
  assign bus.SS      = ~(r_ss_force | w_auto_ss);
  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_mosi;
endmodule

// File: tb/tb_spi_seq_ctrl.sv
// tb/tb_spi_seq_ctrl.sv - directed self-checking bench for spi_seq_ctrl (MISO looped to MOSI)
module tb_spi_seq_ctrl;
  import nhci_spi_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  spi_seq_ctrl_if sif ();

  always #5 CLK = ~CLK;
  assign sif.MISO = sif.MOSI;

  spi_seq_ctrl #(.FIFO_AW(2), .DIV_RESET(12)) dut (
    .CLK(CLK), .RESET(RESET), .bus(sif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    sif.wr_en = 1'b1; sif.wr_addr = a; sif.wr_data = d;
    tick();
    sif.wr_en = 1'b0;
  endtask

  task automatic reg_peek(input logic [1:0] a, output logic [7:0] d);
    sif.rd_addr = a;
    #1 d = sif.rd_data;
  endtask

  task automatic reg_pop(output logic [7:0] d);
    sif.rd_addr = REG_DATA; sif.rd_en = 1'b1;
    #1 d = sif.rd_data;
    tick();
    sif.rd_en = 1'b0;
  endtask

  logic [7:0] rd, mosi_byte;
  logic       prev;
  int         rises, first_i, last_i, spacing_bad, busy_low, n, lows;

  initial begin
    sif.wr_en = 0; sif.wr_addr = 0; sif.wr_data = 0;
    sif.rd_en = 0; sif.rd_addr = 0; sif.INT = 0;

    // reset state
    tick();
    check("rst_ss", sif.SS, 1);
    check("rst_sclk", sif.SCLK, 0);
    check("rst_mosi", sif.MOSI, 0);
    check("rst_irq", sif.irq, 0);
    check("rst_busy", sif.busy, 0);
    reg_peek(REG_STATUS, rd); check("rst_status", rd, 8'h04);
    reg_peek(REG_DIV, rd);    check("rst_div", rd, 8'h0C);
    RESET = 1'b1;
    tick();

    // single byte at DIV=0 with loopback
    reg_wr(REG_DIV, 8'h00);
    reg_wr(REG_CTRL, 8'h01);
    check("ss_force", sif.SS, 0);
    reg_wr(REG_DATA, 8'hA5);
    rises = 0; first_i = -1; last_i = 0; spacing_bad = 0; busy_low = -1; prev = 1'b0; mosi_byte = 0;
    for (int i = 0; i < 40; i++) begin
      if (sif.SCLK && !prev) begin
        if (rises > 0 && i - last_i != 2) spacing_bad++;
        if (first_i < 0) first_i = i;
        last_i = i;
        rises++;
        mosi_byte = {mosi_byte[6:0], sif.MOSI};
      end
      prev = sif.SCLK;
      if (busy_low < 0 && !sif.busy) busy_low = i;
      tick();
    end
    check("t2_rises", rises, 8);
    check("t2_first_rise", first_i, 3);
    check("t2_period", spacing_bad, 0);
    check("t2_mosi_bits", mosi_byte, 8'hA5);
    check("t2_busy_low", busy_low, 19);
    reg_pop(rd); check("t2_rx", rd, 8'hA5);
    reg_peek(REG_STATUS, rd); check("t2_status", rd, 8'h04);
    reg_wr(REG_CTRL, 8'h00);
    check("t2_ss_release", sif.SS, 1);

    // five back-to-back bytes at DIV=255, sixth dropped, RX overflow
    reg_wr(REG_DIV, 8'hFF);
    sif.wr_en = 1'b1; sif.wr_addr = REG_DATA;
    for (int k = 1; k <= 6; k++) begin
      sif.wr_data = 8'(k);
      tick();
    end
    sif.wr_en = 1'b0;
    reg_peek(REG_STATUS, rd); check("t3_tx_full", rd, 8'h07);
    rises = 0; n = 0; prev = sif.SCLK;
    while (sif.busy && n < 25000) begin
      tick(); n++;
      if (sif.SCLK && !prev) rises++;
      prev = sif.SCLK;
    end
    check("t3_timeout", sif.busy, 0);
    check("t3_rises", rises, 40);
    reg_peek(REG_STATUS, rd); check("t4_ovf_status", rd, 8'h08);
    for (int k = 1; k <= 4; k++) begin
      reg_pop(rd);
      check($sformatf("t4_rx%0d", k), rd, 8'(k));
    end
    reg_peek(REG_STATUS, rd); check("t4_empty_ovf", rd, 8'h0C);
    reg_wr(REG_STATUS, 8'h08);
    reg_peek(REG_STATUS, rd); check("t4_w1c", rd, 8'h04);
    reg_pop(rd); check("t4_empty_read", rd, 8'h00);
    reg_peek(REG_STATUS, rd); check("t4_empty_stable", rd, 8'h04);

    // reset mid-transfer
    reg_wr(REG_DIV, 8'h03);
    reg_wr(REG_DATA, 8'h3C);
    rises = 0; n = 0; prev = sif.SCLK;
    while (rises < 4 && n < 200) begin
      tick(); n++;
      if (sif.SCLK && !prev) rises++;
      prev = sif.SCLK;
    end
    check("t5_reach_bit3", rises, 4);
    tick(2);
    check("t5_pre_sclk", sif.SCLK, 1);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("t5_ss", sif.SS, 1);
    check("t5_sclk", sif.SCLK, 0);
    check("t5_mosi", sif.MOSI, 0);
    check("t5_busy", sif.busy, 0);
    reg_peek(REG_STATUS, rd); check("t5_status", rd, 8'h04);
    reg_peek(REG_DIV, rd);    check("t5_div", rd, 8'h0C);
    tick(100);
    reg_peek(REG_STATUS, rd); check("t5_no_rx", rd, 8'h04);

    // slave INT to irq, then two queued bytes framed by SS
    reg_wr(REG_DIV, 8'h00);
    reg_wr(REG_CTRL, 8'h02);
    sif.INT = 1'b1;
    tick(3);
    check("t6_irq_int", sif.irq, 1);
    reg_peek(REG_STATUS, rd); check("t6_int_sync", rd, 8'h14);
    sif.INT = 1'b0;
    tick(3);
    check("t6_irq_clear", sif.irq, 0);
    sif.wr_en = 1'b1; sif.wr_addr = REG_DATA; sif.wr_data = 8'h5A;
    tick();
    sif.wr_data = 8'hC3;
    tick();
    sif.wr_en = 1'b0;
    lows = 0; first_i = -1; last_i = -1;
    for (int i = 1; i <= 45; i++) begin
      if (!sif.SS) begin
        lows++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      tick();
    end
`ifdef SPI_AUTO_SS_EN
    check("t6_ss_first", first_i, 1);
    check("t6_ss_last", last_i, 36);
    check("t6_ss_lows", lows, 36);
`else
    check("t6_ss_idle_high", lows, 0);
`endif
    check("t6_irq_rx", sif.irq, 1);
    reg_pop(rd); check("t6_rx0", rd, 8'h5A);
    reg_pop(rd); check("t6_rx1", rd, 8'hC3);
    tick();
    check("t6_irq_drain", sif.irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
